mips_mem_arbiter: RTL and testbench

Single-port memory arbiter for the MIPS_32 core. It shares one unified synchronous word memory between three requesters: instruction fetch (IF), the MEM-stage load/store port (DM) and a debug/loader port (DBG). The debug port lets the bench or a boot loader fill memory without hierarchical writes. It grants one access per cycle, routes the read data back to the owner one cycle later, and guarantees IF forward progress with a starvation guard.

---
 rtl/mips_mem_arbiter_if.sv | 57 +++++
 rtl/mips_mem_arbiter.sv | 108 ++++++++++
 tb/tb_mips_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the
// unified word memory.
interface mips_mem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;

   logic          dbg_req;
   logic          dbg_we;
   logic          dbg_lock;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic          dbg_rvalid;
   logic [DW-1:0] dbg_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: DBG > DM > IF with an IF starvation guard
// and a debug exclusive-lock mode.
module mips_mem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input logic               clk1,
   input logic               rst_n,
   mips_mem_arbiter_if.slave bus
);

   typedef enum logic {ARB, LOCK} state_t;
   typedef enum logic [1:0] {
      OWN_NONE, OWN_IF, OWN_DM, OWN_DBG
   } owner_t;

   state_t   state;
   state_t   state_d;
   owner_t   owner_q;
   owner_t   owner_d;
   logic [2:0] starve_cnt;

   logic lock_hold;
   logic starved;
   logic g_if;
   logic g_dm;
   logic g_dbg;

   always_comb begin
      lock_hold = (state == LOCK) && bus.dbg_lock;
      starved   = (starve_cnt == 3'(STARVE_MAX));
      g_if      = 1'b0;
      g_dm      = 1'b0;
      g_dbg     = 1'b0;
      if (lock_hold)
         g_dbg = bus.dbg_req;
      else if (starved && bus.if_req)
         g_if = 1'b1;
      else if (bus.dbg_req)
         g_dbg = 1'b1;
      else if (bus.dm_req)
         g_dm = 1'b1;
      else if (bus.if_req)
         g_if = 1'b1;
   end

   assign bus.if_gnt  = g_if;
   assign bus.dm_gnt  = g_dm;
   assign bus.dbg_gnt = g_dbg;

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      owner_d       = OWN_NONE;
      unique case (1'b1)
         g_dbg: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dbg_we;
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
            owner_d       = bus.dbg_we ? OWN_NONE : OWN_DBG;
         end
         g_dm: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dm_we;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
            owner_d       = bus.dm_we ? OWN_NONE : OWN_DM;
         end
         g_if: begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.if_addr;
            owner_d       = OWN_IF;
         end
         default: ;
      endcase
   end

   // Lock persists while dbg_lock stays high, even with dbg_req idle.
   assign state_d = (lock_hold || (g_dbg && bus.dbg_lock)) ? LOCK : ARB;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         owner_q    <= OWN_NONE;
         starve_cnt <= 3'd0;
      end else begin
         state   <= state_d;
         owner_q <= owner_d;
         if (!bus.if_req || g_if)
            starve_cnt <= 3'd0;
         else if (!starved)
            starve_cnt <= starve_cnt + 3'd1;
      end
   end

   assign bus.if_rvalid  = (owner_q == OWN_IF);
   assign bus.dm_rvalid  = (owner_q == OWN_DM);
   assign bus.dbg_rvalid = (owner_q == OWN_DBG);

   assign bus.if_rdata  = bus.if_rvalid  ? bus.mem_rdata : '0;
   assign bus.dm_rdata  = bus.dm_rvalid  ? bus.mem_rdata : '0;
   assign bus.dbg_rdata = bus.dbg_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural synchronous
// word memory behind the arbiter.
module tb_mips_mem_arbiter;

   logic clk1 = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk1 = ~clk1;

   mips_mem_arbiter_if #(.AW(10), .DW(32)) bus ();

   mips_mem_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4)) dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Unwritten words read back a fixed address-derived pattern.
   logic [31:0] mem [1024];
   bit          wr  [1024];

   function automatic logic [31:0] pat(input int a);
      return 32'hA5A5_0000 | 32'(a);
   endfunction

   always @(posedge clk1) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr[bus.mem_addr]  <= 1'b1;
         end else begin
            bus.mem_rdata <= wr[bus.mem_addr] ? mem[bus.mem_addr]
                                              : pat(int'(bus.mem_addr));
         end
      end
   end

   task automatic cyc();
      @(posedge clk1);
      #1;
   endtask

   task automatic idle();
      bus.if_req   = 1'b0;
      bus.dm_req   = 1'b0;
      bus.dbg_req  = 1'b0;
      bus.dbg_lock = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dbg_we   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd5;
      #1;
      checks++;
      if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b001) begin
         errors++;
         $display("FAIL reset_gnt got %b want 001",
                  {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt});
      end
      checks++;
      if (bus.mem_addr !== 10'd5 || bus.mem_en !== 1'b1
          || bus.mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem got addr=%0d en=%b we=%b want 5 1 0",
                  bus.mem_addr, bus.mem_en, bus.mem_we);
      end
      cyc();
      checks++;
      if ({bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_rvalid got %b want 000",
                  {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid});
      end
      rst_n = 1'b1;
      cyc();
      bus.if_req = 1'b0;
      #1;
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== pat(5)) begin
         errors++;
         $display("FAIL reset_release_read got v=%b d=%h want 1 %h",
                  bus.if_rvalid, bus.if_rdata, pat(5));
      end
      cyc();
      checks++;
      if ({bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_rvalid_drop got %b want 000",
                  {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid});
      end
   endtask

   task automatic test_priority();
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 10'd200;
      bus.dbg_wdata = 32'd7;
      #1;
      checks++;
      if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b100
          || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd200) begin
         errors++;
         $display("FAIL prio_dbg_wr got g=%b we=%b a=%0d want 100 1 200",
                  {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt},
                  bus.mem_we, bus.mem_addr);
      end
      cyc();
      idle();
      bus.dm_req  = 1'b1;
      bus.dm_addr = 10'd200;
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd3;
      #1;
      checks++;
      if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b010) begin
         errors++;
         $display("FAIL prio_dm_over_if got %b want 010",
                  {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt});
      end
      checks++;
      if ({bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL prio_write_no_rvalid got %b want 000",
                  {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid});
      end
      cyc();
      bus.dm_req = 1'b0;
      #1;
      checks++;
      if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'd7
          || bus.if_rdata !== 32'd0) begin
         errors++;
         $display("FAIL prio_dm_rdata got v=%b d=%h if_d=%h want 1 7 0",
                  bus.dm_rvalid, bus.dm_rdata, bus.if_rdata);
      end
      checks++;
      if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b001) begin
         errors++;
         $display("FAIL prio_if_next got %b want 001",
                  {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt});
      end
      cyc();
      bus.if_req = 1'b0;
      #1;
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== pat(3)) begin
         errors++;
         $display("FAIL prio_if_rdata got v=%b d=%h want 1 %h",
                  bus.if_rvalid, bus.if_rdata, pat(3));
      end
      checks++;
      if (bus.mem_en !== 1'b0 || bus.mem_addr !== 10'd0
          || bus.mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL idle_mem got en=%b a=%0d d=%h want 0 0 0",
                  bus.mem_en, bus.mem_addr, bus.mem_wdata);
      end
      cyc();
   endtask

   task automatic test_starvation();
      int nxt;
      int last;
      logic [2:0] eg;
      logic [2:0] ev;
      nxt         = 10;
      last        = 0;
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd20;
      for (int k = 1; k <= 6; k++) begin
         bus.dm_addr = 10'(nxt);
         #1;
         eg = (k == 5) ? 3'b001 : 3'b010;
         checks++;
         if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== eg) begin
            errors++;
            $display("FAIL starve_gnt cyc%0d got %b want %b", k,
                     {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt}, eg);
         end
         if (k > 1) begin
            ev = (k == 6) ? 3'b001 : 3'b010;
            checks++;
            if ({bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid} !== ev)
            begin
               errors++;
               $display("FAIL starve_rvalid cyc%0d got %b want %b", k,
                        {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid}, ev);
            end
            checks++;
            if (k == 6 && bus.if_rdata !== pat(20)) begin
               errors++;
               $display("FAIL starve_if_rdata got %h want %h",
                        bus.if_rdata, pat(20));
            end else if (k != 6 && bus.dm_rdata !== pat(last)) begin
               errors++;
               $display("FAIL starve_dm_rdata cyc%0d got %h want %h", k,
                        bus.dm_rdata, pat(last));
            end
         end
         if (k != 5) begin
            last = nxt;
            nxt++;
         end
         cyc();
      end
      idle();
      #1;
      checks++;
      if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== pat(last)) begin
         errors++;
         $display("FAIL starve_dm_resume got v=%b d=%h want 1 %h",
                  bus.dm_rvalid, bus.dm_rdata, pat(last));
      end
      cyc();
   endtask

   task automatic test_lock();
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd7;
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 10'd8;
      for (int k = 0; k <= 10; k++) begin
         bus.dbg_req   = 1'b1;
         bus.dbg_we    = 1'b1;
         bus.dbg_lock  = 1'b1;
         bus.dbg_addr  = 10'(k);
         bus.dbg_wdata = 32'h100 + 32'(k);
         #1;
         checks++;
         if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b100
             || bus.mem_addr !== 10'(k)) begin
            errors++;
            $display("FAIL lock_gnt cyc%0d got g=%b a=%0d want 100 %0d", k,
                     {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt},
                     bus.mem_addr, k);
         end
         cyc();
      end
      bus.dbg_req  = 1'b0;
      bus.dbg_lock = 1'b0;
      bus.dbg_we   = 1'b0;
      #1;
      checks++;
      if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b001
          || bus.mem_addr !== 10'd7) begin
         errors++;
         $display("FAIL lock_release got g=%b a=%0d want 001 7",
                  {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt}, bus.mem_addr);
      end
      cyc();
      bus.if_req = 1'b0;
      #1;
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h107
          || bus.dm_gnt !== 1'b1) begin
         errors++;
         $display("FAIL lock_if_read got v=%b d=%h dmg=%b want 1 107 1",
                  bus.if_rvalid, bus.if_rdata, bus.dm_gnt);
      end
      cyc();
      bus.dm_req = 1'b0;
      #1;
      checks++;
      if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h108) begin
         errors++;
         $display("FAIL lock_dm_read got v=%b d=%h want 1 108",
                  bus.dm_rvalid, bus.dm_rdata);
      end
      cyc();
   endtask

   task automatic test_lock_noreq();
      bus.dbg_lock = 1'b1;
      bus.dm_req   = 1'b1;
      bus.dm_addr  = 10'd9;
      #1;
      cyc();
      #1;
      checks++;
      if ({bus.dbg_gnt, bus.dm_gnt, bus.if_gnt} !== 3'b010) begin
         errors++;
         $display("FAIL lock_noreq got %b want 010",
                  {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt});
      end
      idle();
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 10'd200;
      cyc();
      idle();
      #1;
      checks++;
      if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'd7
          || bus.dm_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL dbg_read got v=%b d=%h dmv=%b want 1 7 0",
                  bus.dbg_rvalid, bus.dbg_rdata, bus.dm_rvalid);
      end
      cyc();
   endtask

   task automatic test_write_read();
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 10'd198;
      bus.dm_wdata = 32'h1234;
      #1;
      checks++;
      if (bus.dm_gnt !== 1'b1 || bus.mem_we !== 1'b1
          || bus.mem_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL wr_grant got g=%b we=%b d=%h want 1 1 1234",
                  bus.dm_gnt, bus.mem_we, bus.mem_wdata);
      end
      cyc();
      idle();
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd198;
      #1;
      checks++;
      if (bus.dm_rvalid !== 1'b0 || bus.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL wr_no_rvalid got dmv=%b ifg=%b want 0 1",
                  bus.dm_rvalid, bus.if_gnt);
      end
      cyc();
      bus.if_req = 1'b0;
      #1;
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1234) begin
         errors++;
         $display("FAIL wr_then_read got v=%b d=%h want 1 1234",
                  bus.if_rvalid, bus.if_rdata);
      end
      cyc();
   endtask

   task automatic test_reset_mid_read();
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 10'd200;
      cyc();
      bus.dm_req = 1'b0;
      #1;
      checks++;
      if (bus.dm_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL midrd_pending got %b want 1", bus.dm_rvalid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid} !== 3'b000
          || bus.dm_rdata !== 32'd0) begin
         errors++;
         $display("FAIL midrd_reset got v=%b d=%h want 000 0",
                  {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid},
                  bus.dm_rdata);
      end
      #1;
      rst_n = 1'b1;
      cyc();
      checks++;
      if ({bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL midrd_after got %b want 000",
                  {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid});
      end
   endtask

   initial begin
      idle();
      bus.if_addr   = '0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.dbg_addr  = '0;
      bus.dbg_wdata = '0;
      test_reset();
      test_priority();
      test_starvation();
      test_lock();
      test_lock_noreq();
      test_write_read();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
